if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter, drives the instruction-memory request handshake, and presents fetched instructions, their PC+4 and a flush strobe to the IF/ID pipeline register. It absorbs variable instruction-memory latency, ID-stage stalls, redirects resolved in later stages, exceptions and external interrupts.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/if_fetch_stage_if.sv | 24 ++
 rtl/if_next_pc.sv | 37 +++
 rtl/if_fetch_stage.sv | 156 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset/vector PCs, fetch FSM encoding,
// the NOP word and the kernel-bit-preserving PC increment.
package mips_pkg;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC  = 32'h8000_0008;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Bit 31 is the kernel bit; only the low 31 bits advance and wrap.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response handshake.
// master: fetch stage (req, addr out; ready, rdata in). slave: memory.
interface if_fetch_stage_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_next_pc.sv
// Next-PC priority mux: exc > irq > redirect > hold > sequential.
// Ports: pc, exc, irq, redirect_valid/pc, advance in; next_pc, pc_plus_4 out.
module if_next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        exc,
    input  logic        irq,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus_4
);

`ifndef IF_IRQ_EN
    logic unused_irq;
    assign unused_irq = irq;
`endif

    always_comb begin
        pc_plus_4 = pc_inc(pc);
        next_pc   = pc;
        if (exc) begin
            next_pc = EXC_VEC;
`ifdef IF_IRQ_EN
        end else if (irq) begin
            next_pc = IRQ_VEC;
`endif
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (advance) begin
            next_pc = pc_plus_4;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, drives imem handshake, feeds IF/ID.
// Ports: clk, reset (async low), imem (master), stall/redirect/exc/irq in;
// instr, pc_plus_4, valid, flush, irq_taken, epc out. IRQ path: IF_IRQ_EN.
module if_fetch_stage
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    if_fetch_stage_if.master    imem,
    input  logic                stall_i,
    input  logic                redirect_valid_i,
    input  logic [31:0]         redirect_pc_i,
    input  logic                exc_i,
    input  logic                irq_i,
    output logic [31:0]         instr_o,
    output logic [31:0]         pc_plus_4_o,
    output logic                instr_valid_o,
    output logic                if_flush_o,
    output logic                irq_taken_o,
    output logic [31:0]         epc_o
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, pc_plus_4;
    logic [31:0]  hold_buf, hold_n;
    logic [31:0]  instr_n, pp4_n;
    logic         valid_n, flush_n;
    logic         released;
    logic         req, ready;
    logic         irq_take, abort, advance;
    logic         exc_act, redirect_act;

    assign req = (state != HOLD) & released;
    // A response only counts against a live request, so a late ready
    // around reset is ignored.
    assign ready = imem.imem_ready_i & req;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc;

    assign exc_act      = exc_i & released;
    assign redirect_act = redirect_valid_i & released;

`ifdef IF_IRQ_EN
    assign irq_take = irq_i & ~pc[31] & ~exc_i & released;
`else
    logic unused_irq_i;
    assign unused_irq_i = irq_i;
    assign irq_take     = 1'b0;
`endif

    assign abort = exc_act | irq_take | redirect_act;

    assign advance = ~abort & ~stall_i &
        (((state == FETCH) & ready) | (state == HOLD));

    if_next_pc u_next_pc (
        .pc             (pc),
        .exc            (exc_act),
        .irq            (irq_take),
        .redirect_valid (redirect_act),
        .redirect_pc    (redirect_pc_i),
        .advance        (advance),
        .next_pc        (pc_n),
        .pc_plus_4      (pc_plus_4)
    );

    always_comb begin
        state_n = state;
        instr_n = instr_o;
        pp4_n   = pc_plus_4_o;
        valid_n = instr_valid_o;
        flush_n = 1'b0;
        hold_n  = hold_buf;
        if (abort) begin
            flush_n = 1'b1;
            valid_n = 1'b0;
            instr_n = NOP;
            // HOLD has no request outstanding; otherwise drain unless
            // the response lands this very cycle.
            state_n = ((state == HOLD) || ready) ? FETCH : DRAIN;
        end else begin
            unique case (state)
                FETCH: begin
                    if (ready && !stall_i) begin
                        instr_n = imem.imem_rdata_i;
                        pp4_n   = pc_plus_4;
                        valid_n = 1'b1;
                    end else if (ready) begin
                        hold_n  = imem.imem_rdata_i;
                        state_n = HOLD;
                    end else if (!stall_i) begin
                        instr_n = NOP;
                        valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        instr_n = hold_buf;
                        pp4_n   = pc_plus_4;
                        valid_n = 1'b1;
                        state_n = FETCH;
                    end
                end
                DRAIN: begin
                    if (ready) state_n = FETCH;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_PC;
            released      <= 1'b0;
            hold_buf      <= NOP;
            instr_o       <= NOP;
            pc_plus_4_o   <= 32'h0;
            instr_valid_o <= 1'b0;
            if_flush_o    <= 1'b0;
        end else begin
            pc            <= pc_n;
            released      <= 1'b1;
            hold_buf      <= hold_n;
            instr_o       <= instr_n;
            pc_plus_4_o   <= pp4_n;
            instr_valid_o <= valid_n;
            if_flush_o    <= flush_n;
        end
    end

`ifdef IF_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_taken_o <= 1'b0;
            epc_o       <= 32'h0;
        end else begin
            irq_taken_o <= irq_take;
            if (irq_take) epc_o <= pc;
        end
    end
`else
    assign irq_taken_o = 1'b0;
    assign epc_o       = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with a scoreboard of
// expected IF/ID deliveries and a simple instruction-memory model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        rv = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        exc = 1'b0;
    logic        irq = 1'b0;
    logic        rdy = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    logic        stall_e = 1'b0;

    logic [31:0] instr, pp4, epc;
    logic        valid, flush, irq_taken;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pp4;
    } exp_t;
    exp_t sb[$];

    if_fetch_stage_if mem_if ();

    if_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .imem             (mem_if),
        .stall_i          (stall),
        .redirect_valid_i (rv),
        .redirect_pc_i    (rpc),
        .exc_i            (exc),
        .irq_i            (irq),
        .instr_o          (instr),
        .pc_plus_4_o      (pp4),
        .instr_valid_o    (valid),
        .if_flush_o       (flush),
        .irq_taken_o      (irq_taken),
        .epc_o            (epc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        if (a == 32'h0000_0020) return 32'hAAAA_AAAA;
        return a ^ 32'h1234_5678;
    endfunction

    assign mem_if.imem_ready_i = rdy;
    always_comb begin
        mem_if.imem_rdata_i = memw(mem_if.imem_addr_o);
        if (ovr_en) mem_if.imem_rdata_i = ovr_data;
    end

    always @(posedge clk) stall_e <= stall;

    // Each new presentation to IF/ID must match the next scoreboard entry.
    always @(negedge clk) begin
        if (reset && valid && !stall_e) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_instr got instr=%h pp4=%h want none",
                         instr, pp4);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr !== e.instr || pp4 !== e.pp4) begin
                    failures++;
                    $display("FAIL sb_instr got instr=%h pp4=%h want instr=%h pp4=%h",
                             instr, pp4, e.instr, e.pp4);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] p4);
        exp_t e;
        e.instr = memw(a);
        e.pp4   = p4;
        sb.push_back(e);
    endtask

    task automatic chk_addr(input string nm, input logic [31:0] want);
        checks++;
        if (mem_if.imem_addr_o !== want) begin
            failures++;
            $display("FAIL %s got addr=%h want %h", nm, mem_if.imem_addr_o, want);
        end
    endtask

    task automatic sb_empty(input string nm);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s got pending=%0d want 0", nm, sb.size());
        end
        sb.delete();
    endtask

    task automatic chk_reset_vals(input string nm);
        checks++;
        if (mem_if.imem_req_o !== 1'b0 || mem_if.imem_addr_o !== 32'h8000_0000 ||
            instr !== 32'h0 || pp4 !== 32'h0 || valid !== 1'b0 ||
            flush !== 1'b0 || irq_taken !== 1'b0 || epc !== 32'h0) begin
            failures++;
            $display("FAIL %s got req=%b addr=%h instr=%h pp4=%h v=%b fl=%b it=%b epc=%h want reset values",
                     nm, mem_if.imem_req_o, mem_if.imem_addr_o, instr, pp4,
                     valid, flush, irq_taken, epc);
        end
    endtask

    task automatic start_at(input logic [31:0] t);
        reset = 1'b0; stall = 1'b0; rv = 1'b0; exc = 1'b0;
        irq = 1'b0; rdy = 1'b0; ovr_en = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        rv = 1'b1; rpc = t; rdy = 1'b1;
        step();
        rv = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; rdy = 1'b1;
        repeat (2) step();
        chk_reset_vals("reset_vals");
        reset = 1'b1;
        step();
        checks++;
        if (mem_if.imem_req_o !== 1'b1 || valid !== 1'b0) begin
            failures++;
            $display("FAIL req_rise got req=%b v=%b want req=1 v=0",
                     mem_if.imem_req_o, valid);
        end
        chk_addr("addr_first", 32'h8000_0000);
        push(32'h8000_0000, 32'h8000_0004);
        push(32'h8000_0004, 32'h8000_0008);
        push(32'h8000_0008, 32'h8000_000C);
        step(); chk_addr("addr_seq1", 32'h8000_0004);
        step(); chk_addr("addr_seq2", 32'h8000_0008);
        step(); chk_addr("addr_seq3", 32'h8000_000C);
        rdy = 1'b0;
        step();
        sb_empty("seq_drained");
    endtask

    task automatic test_wait_states();
        start_at(32'h0000_0010);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || instr !== 32'h0) begin
                failures++;
                $display("FAIL bubble%0d got v=%b instr=%h want v=0 instr=0",
                         i, valid, instr);
            end
        end
        push(32'h0000_0010, 32'h0000_0014);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        step();
        sb_empty("wait_done");
    endtask

    task automatic test_stall();
        start_at(32'h0000_001C);
        push(32'h0000_001C, 32'h0000_0020);
        push(32'h0000_0020, 32'h0000_0024);
        push(32'h0000_0024, 32'h0000_0028);
        step();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (mem_if.imem_req_o !== 1'b0 || valid !== 1'b1 ||
                instr !== memw(32'h1C) || pp4 !== 32'h20) begin
                failures++;
                $display("FAIL stall_hold%0d got req=%b v=%b instr=%h pp4=%h want req=0 frozen",
                         i, mem_if.imem_req_o, valid, instr, pp4);
            end
        end
        stall = 1'b0;
        step();
        chk_addr("stall_resume", 32'h0000_0024);
        step();
        rdy = 1'b0;
        step();
        sb_empty("stall_done");
    endtask

    task automatic test_redirect();
        start_at(32'h0000_0050);
        rdy = 1'b0;
        step();
        rv = 1'b1; rpc = 32'h0000_0100;
        step();
        rv = 1'b0;
        checks++;
        if (flush !== 1'b1 || valid !== 1'b0 || mem_if.imem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL redir_flush got fl=%b v=%b req=%b want 1 0 1",
                     flush, valid, mem_if.imem_req_o);
        end
        chk_addr("redir_addr", 32'h0000_0100);
        rdy = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        step();
        ovr_en = 1'b0;
        checks++;
        if (flush !== 1'b0 || valid !== 1'b0 || instr !== 32'h0) begin
            failures++;
            $display("FAIL drain_discard got fl=%b v=%b instr=%h want 0 0 0",
                     flush, valid, instr);
        end
        push(32'h0000_0100, 32'h0000_0104);
        step();
        rdy = 1'b0;
        step();
        sb_empty("redir_done");
    endtask

    task automatic test_irq();
`ifdef IF_IRQ_EN
        start_at(32'h0000_0040);
        rdy = 1'b0;
        step();
        irq = 1'b1;
        step();
        checks++;
        if (irq_taken !== 1'b1 || epc !== 32'h40 || flush !== 1'b1) begin
            failures++;
            $display("FAIL irq_take got it=%b epc=%h fl=%b want 1 00000040 1",
                     irq_taken, epc, flush);
        end
        chk_addr("irq_vec", 32'h8000_0004);
        rdy = 1'b1;
        push(32'h8000_0004, 32'h8000_0008);
        step();
        checks++;
        if (irq_taken !== 1'b0) begin
            failures++;
            $display("FAIL irq_pulse got it=%b want 0", irq_taken);
        end
        step();
        checks++;
        if (irq_taken !== 1'b0 || epc !== 32'h40) begin
            failures++;
            $display("FAIL irq_kernel got it=%b epc=%h want 0 00000040",
                     irq_taken, epc);
        end
        chk_addr("irq_kernel_addr", 32'h8000_0008);
        irq = 1'b0; rdy = 1'b0;
        step();
        sb_empty("irq_done");
`else
        start_at(32'h0000_0040);
        irq = 1'b1;
        push(32'h0000_0040, 32'h0000_0044);
        step();
        checks++;
        if (irq_taken !== 1'b0 || epc !== 32'h0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL irq_off got it=%b epc=%h fl=%b want 0 0 0",
                     irq_taken, epc, flush);
        end
        chk_addr("irq_off_addr", 32'h0000_0044);
        irq = 1'b0; rdy = 1'b0;
        step();
        sb_empty("irq_off_done");
`endif
    endtask

    task automatic test_wrap();
        start_at(32'h7FFF_FFFC);
        push(32'h7FFF_FFFC, 32'h0000_0000);
        step();
        chk_addr("wrap_user", 32'h0000_0000);
        rdy = 1'b0;
        step();
        sb_empty("wrap_user_done");
        start_at(32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h8000_0000);
        step();
        chk_addr("wrap_kernel", 32'h8000_0000);
        rdy = 1'b0;
        step();
        sb_empty("wrap_kernel_done");
    endtask

    task automatic test_exc_reset();
        start_at(32'h0000_0060);
        rdy = 1'b0;
        exc = 1'b1; rv = 1'b1; rpc = 32'h0000_0300;
        step();
        exc = 1'b0; rv = 1'b0;
        chk_addr("exc_wins", 32'h8000_0008);
        checks++;
        if (flush !== 1'b1) begin
            failures++;
            $display("FAIL exc_flush got fl=%b want 1", flush);
        end
        step();
        reset = 1'b0;
        #1;
        chk_reset_vals("reset_mid_drain");
        rdy = 1'b1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
        step();
        reset = 1'b1;
        step();
        checks++;
        if (valid !== 1'b0 || mem_if.imem_req_o !== 1'b1) begin
            failures++;
            $display("FAIL late_ready got v=%b req=%b want 0 1",
                     valid, mem_if.imem_req_o);
        end
        chk_addr("post_reset_addr", 32'h8000_0000);
        ovr_en = 1'b0;
        push(32'h8000_0000, 32'h8000_0004);
        step();
        rdy = 1'b0;
        step();
        sb_empty("exc_done");
    endtask

    initial begin
        test_reset();
        test_wait_states();
        test_stall();
        test_redirect();
        test_irq();
        test_wrap();
        test_exc_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
